// File: rtl/axis_mul_arbiter.sv
// rtl/axis_mul_arbiter.sv - two-requester arbitrated signed 16x16 multiplier pipeline
//
// Purpose:
//   Two requesters share one fully pipelined signed multiplier. When both
//   are valid in the same cycle, a one-bit priority pointer picks the winner.
//   After every accepted operand pair the pointer moves to the requester that
//   was not granted, so a requester that keeps streaming cannot lock out the
//   other. Each accepted pair enters a NUM_STAGE-deep pipeline together with
//   a valid bit and an owner id. Results leave in accept order through a
//   valid/ready output register. A single advance enable stalls the whole
//   pipe whenever the output register is full and the consumer is not ready.
//
// Ports:
//   ap_clk                 clock, all state updates on the rising edge
//   ap_rst                 synchronous active-high reset
//   req0_a, req0_b         requester 0 signed operands
//   req0_valid/req0_ready  requester 0 handshake (ready is combinational)
//   req1_a, req1_b         requester 1 signed operands
//   req1_valid/req1_ready  requester 1 handshake (ready is combinational)
//   res_p                  low DOUT_WIDTH bits of the signed product
//   res_id                 index of the requester that owns res_p
//   res_valid/res_ready    result handshake
//   busy                   any pipeline stage (including output) occupied
//
// Parameters:
//   NUM_STAGE   cycles from operand accept to result register, 1..4
//   DOUT_WIDTH  result width, low bits of the 32-bit signed product

module axis_mul_arbiter #(
   parameter int NUM_STAGE  = 2,
   parameter int DOUT_WIDTH = 24
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic [15:0]           req0_a,
   input  logic [15:0]           req0_b,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [15:0]           req1_a,
   input  logic [15:0]           req1_b,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   output logic [DOUT_WIDTH-1:0] res_p,
   output logic                  res_id,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic                  busy
);

   logic                  w_adv;
   logic                  w_gnt1;
   logic                  w_fire;
   logic signed [15:0]    w_op_a;
   logic signed [15:0]    w_op_b;
   logic signed [31:0]    w_prod_full;
   logic [DOUT_WIDTH-1:0] w_prod;

   logic                  r_prio;
   logic [NUM_STAGE-1:0]  r_vld;
   logic [NUM_STAGE-1:0]  r_id;
   logic [DOUT_WIDTH-1:0] r_p [NUM_STAGE];

   // The whole pipe moves together: it may advance whenever the output
   // register is empty or is being drained this cycle.
   assign w_adv = !r_vld[NUM_STAGE-1] || res_ready;

   // Requester 1 wins when it is the only one asking, or when both ask and
   // the pointer favours it. Otherwise any request present belongs to req 0.
   assign w_gnt1 = req1_valid && (!req0_valid || r_prio);

   // Exactly one accept per cycle at most; reset masks both readies.
   assign w_fire     = !ap_rst && w_adv && (req0_valid || req1_valid);
   assign req0_ready = w_fire && !w_gnt1;
   assign req1_ready = w_fire && w_gnt1;

   // Operands are muxed from the granted requester and multiplied in the
   // accept cycle; the first pipeline register captures the product.
   assign w_op_a      = w_gnt1 ? req1_a : req0_a;
   assign w_op_b      = w_gnt1 ? req1_b : req0_b;
   assign w_prod_full = w_op_a * w_op_b;

   // Narrow results keep the low bits (plain truncation); wide results
   // sign-extend the full product.
   if (DOUT_WIDTH <= 32) begin : g_trunc
      logic w_prod_unused;
      assign w_prod        = w_prod_full[DOUT_WIDTH-1:0];
      assign w_prod_unused = ^w_prod_full;
   end else begin : g_sext
      assign w_prod = {{(DOUT_WIDTH-32){w_prod_full[31]}}, w_prod_full};
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_prio <= 1'b0;
         r_vld  <= '0;
         r_id   <= '0;
         for (int i = 0; i < NUM_STAGE; i++) begin
            r_p[i] <= '0;
         end
      end else begin
         // Pointer moves to the loser of this accept; idle cycles keep it.
         if (w_fire) begin
            r_prio <= !w_gnt1;
         end
         if (w_adv) begin
            r_vld[0] <= w_fire;
            // Data and id registers load only behind a valid entry, so
            // operand wiggles without an accept never reach the outputs.
            if (w_fire) begin
               r_id[0] <= w_gnt1;
               r_p[0]  <= w_prod;
            end
            for (int i = 1; i < NUM_STAGE; i++) begin
               r_vld[i] <= r_vld[i-1];
               if (r_vld[i-1]) begin
                  r_id[i] <= r_id[i-1];
                  r_p[i]  <= r_p[i-1];
               end
            end
         end
      end
   end

   // The last stage doubles as the output register.
   assign res_valid = r_vld[NUM_STAGE-1];
   assign res_id    = r_id[NUM_STAGE-1];
   assign res_p     = r_p[NUM_STAGE-1];
   assign busy      = |r_vld;

endmodule

// File: tb/tb_axis_mul_arbiter.sv
// tb/tb_axis_mul_arbiter.sv - self-checking bench for axis_mul_arbiter
module tb_axis_mul_arbiter;

   localparam int NS = 2;
   localparam int DW = 24;

   logic          ap_clk = 1'b0;
   logic          ap_rst = 1'b1;
   logic [15:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b1;
   wire           req0_ready, req1_ready, res_id, res_valid, busy;
   wire  [DW-1:0] res_p;

   logic [15:0]   sw_a = '0, sw_b = '0;
   logic          sw_v = 1'b0;
   wire  [2:0]    sw_rdy, sw_r1, sw_vld, sw_id, sw_busy;
   wire  [DW-1:0] sw_p [3];

   always #5 ap_clk = ~ap_clk;

   axis_mul_arbiter #(.NUM_STAGE(NS), .DOUT_WIDTH(DW)) u_dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .req0_a(req0_a), .req0_b(req0_b), .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_valid(req1_valid), .req1_ready(req1_ready),
      .res_p(res_p), .res_id(res_id), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy)
   );

   for (genvar g = 0; g < 3; g++) begin : g_sw
      axis_mul_arbiter #(.NUM_STAGE(g == 0 ? 1 : g + 2), .DOUT_WIDTH(DW)) u_sw (
         .ap_clk(ap_clk), .ap_rst(ap_rst),
         .req0_a(sw_a), .req0_b(sw_b), .req0_valid(sw_v), .req0_ready(sw_rdy[g]),
         .req1_a(16'h0), .req1_b(16'h0), .req1_valid(1'b0), .req1_ready(sw_r1[g]),
         .res_p(sw_p[g]), .res_id(sw_id[g]), .res_valid(sw_vld[g]), .res_ready(1'b1),
         .busy(sw_busy[g])
      );
   end

   int tests = 0;
   int failed = 0;

   // Reference model: a queue of accepted results, each aging one step per
   // advancing cycle; the head is presented once it has aged NS cycles.
   typedef struct {
      logic          id;
      logic [DW-1:0] p;
      int            age;
   } ent_t;
   ent_t mq[$];
   logic mprio = 1'b0;

   logic          exp_r0, exp_r1, exp_v, exp_busy, exp_id, exp_adv, exp_g1, exp_fire;
   logic [DW-1:0] exp_p;
   logic [28:0]   obs, expv;

   function automatic logic [DW-1:0] mprod(input logic [15:0] a, input logic [15:0] b);
      int sa, sb, p;
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
      return p[DW-1:0];
   endfunction

   function automatic int sw_ns(input int g);
      return (g == 0) ? 1 : g + 2;
   endfunction

   // Computes the model's expectation for the current inputs and samples the DUT.
   task automatic apply();
      logic vis;
      vis      = (mq.size() > 0) && (mq[0].age == NS);
      exp_v    = vis;
      exp_id   = 1'b0;
      exp_p    = '0;
      if (vis) begin
         exp_id = mq[0].id;
         exp_p  = mq[0].p;
      end
      exp_adv  = !vis || res_ready;
      exp_g1   = req1_valid && (!req0_valid || mprio);
      exp_fire = !ap_rst && exp_adv && (req0_valid || req1_valid);
      exp_r0   = exp_fire && !exp_g1;
      exp_r1   = exp_fire && exp_g1;
      exp_busy = mq.size() > 0;
      #1;
      obs  = {req0_ready, req1_ready, res_valid, busy, res_valid ? {res_id, res_p} : 25'h0};
      expv = {exp_r0, exp_r1, exp_v, exp_busy, exp_v ? {exp_id, exp_p} : 25'h0};
   endtask

   task automatic tick();
      ent_t e;
      @(posedge ap_clk);
      if (ap_rst) begin
         mq.delete();
         mprio = 1'b0;
      end else if (exp_adv) begin
         if (exp_v) void'(mq.pop_front());
         for (int i = 0; i < mq.size(); i++) mq[i].age++;
         if (exp_fire) begin
            e.id  = exp_g1;
            e.p   = exp_g1 ? mprod(req1_a, req1_b) : mprod(req0_a, req0_b);
            e.age = 1;
            mq.push_back(e);
            mprio = !exp_g1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      ap_rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         apply();
         tests++;
         if (obs !== expv) begin failed++; $display("FAIL reset k=%0d: got %h want %h", k, obs, expv); end
         tests++;
         if ({res_id, res_p} !== 25'h0) begin failed++; $display("FAIL reset_vals: got %h want 0", {res_id, res_p}); end
         tick();
      end
      ap_rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_single();
      req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'hFFFB;
      for (int k = 0; k < 4; k++) begin
         apply();
         tests++;
         if (obs !== expv) begin failed++; $display("FAIL single k=%0d: got %h want %h", k, obs, expv); end
         if (k == 2) begin
            tests++;
            if ({res_valid, res_id, res_p} !== {1'b1, 1'b0, 24'hFFFFF1}) begin
               failed++; $display("FAIL single_res: got %h want %h", {res_valid, res_id, res_p}, {1'b1, 1'b0, 24'hFFFFF1});
            end
         end
         if (k == 3) begin
            tests++;
            if (res_valid !== 1'b0) begin failed++; $display("FAIL single_drop: got %b want 0", res_valid); end
         end
         tick();
         req0_valid = 1'b0;
      end
   endtask

   task automatic test_alternate();
      ap_rst = 1'b1; apply(); tick(); ap_rst = 1'b0;
      req0_valid = 1'b1; req0_a = 16'd1; req0_b = 16'd1;
      req1_valid = 1'b1; req1_a = 16'd2; req1_b = 16'd2;
      for (int k = 0; k < 11; k++) begin
         if (k == 8) begin req0_valid = 1'b0; req1_valid = 1'b0; end
         apply();
         tests++;
         if (obs !== expv) begin failed++; $display("FAIL alternate k=%0d: got %h want %h", k, obs, expv); end
         if (k < 8) begin
            tests++;
            if ({req0_ready, req1_ready} !== {k[0] == 1'b0, k[0] == 1'b1}) begin
               failed++; $display("FAIL alt_grant k=%0d: got %b%b want %b%b", k, req0_ready, req1_ready, k[0] == 1'b0, k[0] == 1'b1);
            end
         end
         if (k >= 2 && k < 10) begin
            tests++;
            if ({res_valid, res_p} !== {1'b1, (k[0] ? 24'd4 : 24'd1)}) begin
               failed++; $display("FAIL alt_res k=%0d: got %h want %h", k, {res_valid, res_p}, {1'b1, (k[0] ? 24'd4 : 24'd1)});
            end
         end
         tick();
      end
   endtask

   task automatic test_overflow();
      req1_valid = 1'b1; req1_a = 16'h7FFF; req1_b = 16'h7FFF;
      for (int k = 0; k < 4; k++) begin
         apply();
         tests++;
         if (obs !== expv) begin failed++; $display("FAIL overflow k=%0d: got %h want %h", k, obs, expv); end
         if (k == 2) begin
            tests++;
            if ({res_valid, res_id, res_p} !== {1'b1, 1'b1, 24'hFF0001}) begin
               failed++; $display("FAIL overflow_res: got %h want %h", {res_valid, res_id, res_p}, {1'b1, 1'b1, 24'hFF0001});
            end
         end
         tick();
         req1_valid = 1'b0;
      end
   endtask

   task automatic test_backpressure();
      logic [25:0] want;
      for (int k = 0; k < 8; k++) begin
         req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
         case (k)
            0: begin req0_valid = 1'b1; req0_a = 16'd5; req0_b = 16'd6; end
            1: begin req1_valid = 1'b1; req1_a = 16'hFFF9; req1_b = 16'd8; end
            2, 3, 4: begin
               res_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
               req0_a = 16'd9; req1_a = 16'd11;
            end
            default: ;
         endcase
         apply();
         tests++;
         if (obs !== expv) begin failed++; $display("FAIL backpressure k=%0d: got %h want %h", k, obs, expv); end
         if (k >= 2) begin
            want = (k <= 5) ? {1'b1, 1'b0, 24'd30} : (k == 6) ? {1'b1, 1'b1, 24'hFFFFC8} : 26'h0;
            tests++;
            if ((k == 7 ? {res_valid, 25'h0} : {res_valid, res_id, res_p}) !== want) begin
               failed++; $display("FAIL bp_res k=%0d: got %h want %h", k, {res_valid, res_id, res_p}, want);
            end
         end
         if (k >= 2 && k <= 4) begin
            tests++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
               failed++; $display("FAIL bp_ready k=%0d: got %b%b want 00", k, req0_ready, req1_ready);
            end
         end
         tick();
      end
      res_ready = 1'b1;
   endtask

   task automatic test_reset_midflight();
      for (int k = 0; k < 8; k++) begin
         req0_valid = 1'b0; req1_valid = 1'b0; ap_rst = 1'b0;
         req0_a = 16'(k + 20); req0_b = 16'd3; req1_a = 16'(k + 40); req1_b = 16'd5;
         case (k)
            0: req1_valid = 1'b1;
            1: req0_valid = 1'b1;
            2: begin ap_rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; end
            3: begin req0_valid = 1'b1; req1_valid = 1'b1; end
            default: ;
         endcase
         apply();
         tests++;
         if (obs !== expv) begin failed++; $display("FAIL midreset k=%0d: got %h want %h", k, obs, expv); end
         if (k == 3) begin
            tests++;
            if ({req0_ready, req1_ready, res_valid, busy} !== 4'b1000) begin
               failed++; $display("FAIL midreset_state: got %b want 1000", {req0_ready, req1_ready, res_valid, busy});
            end
         end
         tick();
      end
      ap_rst = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         res_ready  = ($urandom_range(0, 3) != 0);
         req0_a = 16'($urandom); req0_b = 16'($urandom);
         req1_a = 16'($urandom); req1_b = 16'($urandom);
         apply();
         tests++;
         if (obs !== expv) begin failed++; $display("FAIL random k=%0d: got %h want %h", k, obs, expv); end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         apply();
         tests++;
         if (obs !== expv) begin failed++; $display("FAIL random_drain k=%0d: got %h want %h", k, obs, expv); end
         tick();
      end
   endtask

   task automatic test_latency_sweep();
      logic [DW-1:0] p;
      logic [26:0]   o, w;
      sw_a = 16'($urandom); sw_b = 16'($urandom); sw_v = 1'b1;
      p = mprod(sw_a, sw_b);
      #1;
      tests++;
      if ({sw_rdy, sw_r1} !== 6'b111000) begin failed++; $display("FAIL sweep_ready: got %b want 111000", {sw_rdy, sw_r1}); end
      @(posedge ap_clk); #1;
      sw_v = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         for (int g = 0; g < 3; g++) begin
            o = {sw_vld[g], sw_busy[g], sw_vld[g] ? {sw_id[g], sw_p[g]} : 25'h0};
            w = {k == sw_ns(g), k <= sw_ns(g), k == sw_ns(g) ? {1'b0, p} : 25'h0};
            tests++;
            if (o !== w) begin failed++; $display("FAIL sweep ns=%0d k=%0d: got %h want %h", sw_ns(g), k, o, w); end
         end
         @(posedge ap_clk); #1;
      end
   endtask

   initial begin
      repeat (2) @(posedge ap_clk);
      #1;
      test_reset();
      test_single();
      test_alternate();
      test_overflow();
      test_backpressure();
      test_reset_midflight();
      test_random();
      test_latency_sweep();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
